can_rx_frame_fifo: RTL and testbench

- Sits directly downstream of the CAN frame-level receiver and consumes its per-frame outputs (rx_valid pulse, id, ide, rtr, len, 64-bit data).
- Applies an ID acceptance filter to each frame and buffers accepted frames in a FIFO.
- Presents buffered frames to the host side with a valid/ready handshake.
- Drives rx_ack back to the receiver, which uses it to decide whether to send the dominant ACK bit; rx_ack is high only for frames that were stored.

---
 rtl/can_rx_frame_fifo.sv | 135 +++++++++++++
 tb/tb_can_rx_frame_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_frame_fifo.sv
// CAN receive frame buffer: ID acceptance filter, frame FIFO, and bus ACK request.
// Accepted frames are queued for the host; rejected or overflowing frames are counted.
module can_rx_frame_fifo #(
    parameter int unsigned AW         = 3,
    parameter logic [28:0] FILT_ID    = 29'h0,
    parameter logic [28:0] FILT_MASK  = 29'h0,
    parameter logic [1:0]  FILT_IDE   = 2'd2,
    parameter logic        ACCEPT_RTR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [28:0]   rx_id,
    input  logic          rx_ide,
    input  logic          rx_rtr,
    input  logic [3:0]    rx_len,
    input  logic [63:0]   rx_data,
    output logic          rx_ack,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [28:0]   out_id,
    output logic          out_ide,
    output logic          out_rtr,
    output logic [3:0]    out_len,
    output logic [63:0]   out_data,
    output logic [AW:0]   count,
    output logic [15:0]   drop_full,
    output logic [15:0]   drop_filt
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  len;
        logic [63:0] data;
    } frame_t;

    // EVAL is resolved combinationally in the rx_valid cycle; never registered
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        ACKHOLD = 2'd2
    } state_t;

    frame_t        mem [DEPTH];
    frame_t        head;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    state_t        state;

    logic ide_ok;
    logic match;
    logic pop;
    logic space;
    logic push;

    assign ide_ok = (FILT_IDE == 2'd2) || (rx_ide == FILT_IDE[0]);
    assign match  = (((rx_id ^ FILT_ID) & FILT_MASK) == 29'h0)
                  && ide_ok && (ACCEPT_RTR || !rx_rtr);

    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready;
    assign space     = (cnt != FULL) || pop;
    assign push      = rx_valid && match && space;

    assign head     = mem[rptr];
    assign out_id   = head.id;
    assign out_ide  = head.ide;
    assign out_rtr  = head.rtr;
    assign out_len  = head.len;
    assign out_data = head.data;
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr] <= '{id: rx_id, ide: rx_ide, rtr: rx_rtr,
                           len: rx_len, data: rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_full <= '0;
            drop_filt <= '0;
        end else if (rx_valid) begin
            if (!match) begin
                if (drop_filt != 16'hFFFF) drop_filt <= drop_filt + 1'b1;
            end else if (!space) begin
                if (drop_full != 16'hFFFF) drop_full <= drop_full + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rx_ack <= 1'b0;
        end else begin
            unique case (state)
                IDLE, EVAL, ACKHOLD: begin
                    if (rx_valid) begin
                        state  <= ACKHOLD;
                        rx_ack <= push;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rx_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Bench for can_rx_frame_fifo: three filter configurations against a queue model.
// Directed frames with literal expectations pin the model at key points.
module tb_can_rx_frame_fifo;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  len;
        logic [63:0] data;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [28:0] rx_id = '0;
    logic        rx_ide = 1'b0;
    logic        rx_rtr = 1'b0;
    logic [3:0]  rx_len = '0;
    logic [63:0] rx_data = '0;
    logic        out_ready = 1'b0;

    logic        ack   [3];
    logic        ovld  [3];
    logic [28:0] oid   [3];
    logic        oide  [3];
    logic        ortr  [3];
    logic [3:0]  olen  [3];
    logic [63:0] odata [3];
    logic [3:0]  cnt   [3];
    logic [15:0] dfull [3];
    logic [15:0] dfilt [3];

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    frame_t      mq [3][$];
    logic [15:0] m_dfull [3];
    logic [15:0] m_dfilt [3];
    logic        m_ack [3];

    always #5 clk = ~clk;

    can_rx_frame_fifo u_def (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_id(rx_id),
        .rx_ide(rx_ide), .rx_rtr(rx_rtr), .rx_len(rx_len), .rx_data(rx_data),
        .rx_ack(ack[0]), .out_valid(ovld[0]), .out_ready(out_ready),
        .out_id(oid[0]), .out_ide(oide[0]), .out_rtr(ortr[0]),
        .out_len(olen[0]), .out_data(odata[0]), .count(cnt[0]),
        .drop_full(dfull[0]), .drop_filt(dfilt[0])
    );

    can_rx_frame_fifo #(
        .FILT_ID(29'h123), .FILT_MASK(29'h7F0), .FILT_IDE(2'd0)
    ) u_flt (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_id(rx_id),
        .rx_ide(rx_ide), .rx_rtr(rx_rtr), .rx_len(rx_len), .rx_data(rx_data),
        .rx_ack(ack[1]), .out_valid(ovld[1]), .out_ready(out_ready),
        .out_id(oid[1]), .out_ide(oide[1]), .out_rtr(ortr[1]),
        .out_len(olen[1]), .out_data(odata[1]), .count(cnt[1]),
        .drop_full(dfull[1]), .drop_filt(dfilt[1])
    );

    can_rx_frame_fifo #(.ACCEPT_RTR(1'b0)) u_rtr (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_id(rx_id),
        .rx_ide(rx_ide), .rx_rtr(rx_rtr), .rx_len(rx_len), .rx_data(rx_data),
        .rx_ack(ack[2]), .out_valid(ovld[2]), .out_ready(out_ready),
        .out_id(oid[2]), .out_ide(oide[2]), .out_rtr(ortr[2]),
        .out_len(olen[2]), .out_data(odata[2]), .count(cnt[2]),
        .drop_full(dfull[2]), .drop_filt(dfilt[2])
    );

    function automatic bit accepts(int i, logic [28:0] id, logic ide, logic rtr);
        case (i)
            1:       return (id[10:4] == 7'h12) && !ide;
            2:       return !rtr;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mq[i].delete();
                m_dfull[i] = '0;
                m_dfilt[i] = '0;
                m_ack[i] = 1'b0;
            end else begin
                bit pop_now;
                pop_now = (mq[i].size() != 0) && out_ready;
                if (rx_valid) begin
                    if (!accepts(i, rx_id, rx_ide, rx_rtr)) begin
                        m_ack[i] = 1'b0;
                        if (m_dfilt[i] != 16'hFFFF) m_dfilt[i]++;
                    end else if (mq[i].size() >= 8 && !pop_now) begin
                        m_ack[i] = 1'b0;
                        if (m_dfull[i] != 16'hFFFF) m_dfull[i]++;
                    end else begin
                        m_ack[i] = 1'b1;
                    end
                end
                if (pop_now) void'(mq[i].pop_front());
                if (rx_valid && m_ack[i])
                    mq[i].push_back('{rx_id, rx_ide, rx_rtr, rx_len, rx_data});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_valid", i), 128'(ovld[i]), 128'(mq[i].size() != 0));
                chk($sformatf("u%0d_count", i), 128'(cnt[i]), 128'(mq[i].size()));
                chk($sformatf("u%0d_ack", i), 128'(ack[i]), 128'(m_ack[i]));
                chk($sformatf("u%0d_dfull", i), 128'(dfull[i]), 128'(m_dfull[i]));
                chk($sformatf("u%0d_dfilt", i), 128'(dfilt[i]), 128'(m_dfilt[i]));
                if (mq[i].size() != 0)
                    chk($sformatf("u%0d_head", i),
                        128'({oid[i], oide[i], ortr[i], olen[i], odata[i]}),
                        128'(mq[i][0]));
            end
        end
    end

    task automatic send(input logic [28:0] id, input logic ide, input logic rtr,
                        input logic [3:0] len, input logic [63:0] d,
                        input logic rdy);
        rx_valid = 1'b1;
        rx_id = id;
        rx_ide = ide;
        rx_rtr = rtr;
        rx_len = len;
        rx_data = d;
        out_ready = rdy;
        @(negedge clk);
        rx_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);
        chk_en = 1;
        chk("rst_count", 128'(cnt[0]), 128'd0);
        chk("rst_valid", 128'(ovld[0]), 128'd0);

        send(29'h456, 1'b0, 1'b0, 4'd4, 64'hDEADBEEF, 1'b0);
        chk("t1_ack", 128'(ack[0]), 128'd1);
        chk("t1_valid", 128'(ovld[0]), 128'd1);
        chk("t1_id", 128'(oid[0]), 128'h456);
        chk("t1_len", 128'(olen[0]), 128'd4);
        chk("t1_count", 128'(cnt[0]), 128'd1);

        for (int k = 1; k < 8; k++)
            send(29'h120 + 29'(k), 1'b0, 1'b0, 4'(k), 64'(k) << 8, 1'b0);
        chk("t2_full", 128'(cnt[0]), 128'd8);
        send(29'h3AA, 1'b0, 1'b0, 4'd2, 64'h55AA, 1'b0);
        chk("t2_ack9", 128'(ack[0]), 128'd0);
        chk("t2_dfull", 128'(dfull[0]), 128'd1);
        chk("t2_count", 128'(cnt[0]), 128'd8);

        send(29'h3BB, 1'b0, 1'b0, 4'd3, 64'h77, 1'b1);
        chk("t3_ack", 128'(ack[0]), 128'd1);
        chk("t3_count", 128'(cnt[0]), 128'd8);
        chk("t3_dfull", 128'(dfull[0]), 128'd1);
        chk("t3_head", 128'(oid[0]), 128'h121);

        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        chk("t3_drained", 128'(cnt[0]), 128'd0);

        do_reset(2);
        send(29'h12A, 1'b0, 1'b0, 4'd1, 64'h1, 1'b0);
        chk("t4_acc", 128'(ack[1]), 128'd1);
        send(29'h133, 1'b0, 1'b0, 4'd1, 64'h2, 1'b0);
        chk("t4_rej_ack", 128'(ack[1]), 128'd0);
        chk("t4_rej_cnt", 128'(dfilt[1]), 128'd1);
        send(29'h12A, 1'b1, 1'b0, 4'd1, 64'h3, 1'b0);
        chk("t4_ide_rej", 128'(dfilt[1]), 128'd2);

        send(29'h55, 1'b0, 1'b1, 4'd8, 64'h0, 1'b0);
        chk("t5_rtr_ack", 128'(ack[2]), 128'd0);
        chk("t5_rtr_filt", 128'(dfilt[2]), 128'd1);
        chk("t5_rtr_count", 128'(cnt[2]), 128'd3);

        for (int k = 0; k < 6; k++) begin
            rx_valid = 1'b1;
            rx_id = 29'h120 + 29'(k * 5);
            rx_ide = k[0];
            rx_rtr = k[1];
            rx_len = 4'(k);
            rx_data = 64'hA5A5_0000_0000_0000 | 64'(k);
            out_ready = k[0];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        rx_valid = 1'b1;
        rx_id = 29'h121;
        do_reset(1);
        rx_valid = 1'b0;
        chk("t6_count", 128'(cnt[0]), 128'd0);
        chk("t6_valid", 128'(ovld[0]), 128'd0);
        chk("t6_ack", 128'(ack[0]), 128'd0);
        chk("t6_dfilt", 128'(dfilt[1]), 128'd0);
        send(29'h7FF, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF, 1'b0);
        chk("t6_id", 128'(oid[0]), 128'h7FF);
        chk("t6_data", 128'(odata[0]), 128'h0123456789ABCDEF);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
